mc_control_fsm: RTL

//  Parametrised multicycle MIPS main control FSM, successor of the fixed 10-state control unit.

---
 rtl/mc_control_fsm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM with memory wait states, memory timeout, illegal-opcode trap and retire pulse.
// Optional addi path (I_EXEC/I_WB) enabled by defining MC_CTRL_IMM_ALU_EN.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal_op,
  output logic       mem_fault
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_TRAP      = 4'd11;
`ifdef MC_CTRL_IMM_ALU_EN
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd12;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = TIMEOUT_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             illegal_op_reg, mem_fault_reg;
  logic             set_illegal, set_fault;
  logic             mem_wait;
  logic             timeout_hit;

  // Only the three memory-handshake states can stall on mem_ready.
  assign mem_wait    = ((state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                        (state_reg == S_MEM_WRITE)) && !mem_ready;
  assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      cnt_reg        <= '0;
      illegal_op_reg <= 1'b0;
      mem_fault_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (set_illegal) illegal_op_reg <= 1'b1;
      if (set_fault)   mem_fault_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    case (state_reg)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MC_CTRL_IMM_ALU_EN
          OP_ADDI:      state_next = S_I_EXEC;
`endif
          default: begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
`ifdef MC_CTRL_IMM_ALU_EN
      S_I_EXEC:    state_next = S_I_WB;
      S_I_WB:      state_next = S_FETCH;
`endif
      default:     state_next = S_TRAP;
    endcase
    // A ready memory on the limit cycle takes the normal path instead.
    if (mem_wait && timeout_hit) begin
      state_next = S_TRAP;
      set_fault  = 1'b1;
    end
  end

  always_comb begin
    if (state_next != state_reg)
      cnt_next = '0;
    else if (mem_wait && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + 1'b1;
    else
      cnt_next = cnt_reg;
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    retire      = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:    ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          retire      = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          retire   = 1'b1;
        end
`ifdef MC_CTRL_IMM_ALU_EN
        S_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_I_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state      = state_reg;
  assign illegal_op = illegal_op_reg;
  assign mem_fault  = mem_fault_reg;

endmodule
